// File: rtl/fadd_sub_pipe.sv
// fadd_sub_pipe: three-stage pipelined floating-point adder/subtractor.
//
// Stages:
//   S1 unpack, special-case detection, magnitude compare/swap, alignment
//   S2 significand add/subtract
//   S3 normalise, round, pack (result/flags registered at the output)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   operand pair accepted this cycle (== pipeline advance)
//   a_operand  operand A (sign, exponent, stored mantissa)
//   b_operand  operand B
//   sub        1: A-B, 0: A+B
//   out_valid  result valid
//   out_ready  downstream accepts result
//   result     sum/difference
//   flags      {invalid, overflow, inexact, zero}, qualified by out_valid
//
// Configuration macro:
//   FADD_SUB_PIPE_RNE_EN  defined: round-to-nearest-even, overflow -> Inf
//                         undefined: truncate, overflow -> max finite
//
// Subnormal inputs are flushed to zero and subnormal results flush to a
// signed zero.

module fadd_sub_pipe #(
    parameter int unsigned I_EXP  = 8,
    parameter int unsigned I_MNT  = 23,
    parameter int unsigned I_DATA = I_EXP + I_MNT + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [I_DATA-1:0] a_operand,
    input  logic [I_DATA-1:0] b_operand,
    input  logic              sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [I_DATA-1:0] result,
    output logic [3:0]        flags
);

    // Working significand: {hidden, mantissa, guard, round, sticky}
    localparam int unsigned SW        = I_MNT + 4;
    localparam int unsigned SHW       = $clog2(SW + 1);
    localparam int unsigned SHIFT_MAX = I_MNT + 3;
    localparam int unsigned EW        = I_EXP + 2;
    localparam logic signed [EW-1:0] EXP_MAX_S = EW'((1 << I_EXP) - 1);
    localparam logic [I_DATA-1:0] QNAN =
        {1'b0, {I_EXP{1'b1}}, 1'b1, {(I_MNT-1){1'b0}}};

    logic adv;

    // ---------------- S1 combinational ----------------
    logic              a_sign, b_sign;
    logic [I_EXP-1:0]  a_exp, b_exp;
    logic [I_MNT-1:0]  a_man, b_man;
    logic              a_nan, b_nan, a_inf, b_inf;
    logic [I_DATA-2:0] a_mag, b_mag, big_mag, small_mag;
    logic              a_ge, big_sign;
    logic [I_EXP-1:0]  big_exp, small_exp, diff;
    logic [SHW-1:0]    shamt;
    logic [SW-1:0]     big_sig, small_sig, mask, small_al;
    logic              spec_d, spec_inv_d;
    logic [I_DATA-1:0] spec_res_d;

    // ---------------- stage registers ----------------
    logic              v1_q, spec1_q, spec_inv1_q, sign1_q, eff_sub1_q, zsign1_q;
    logic [I_DATA-1:0] spec_res1_q;
    logic [I_EXP-1:0]  exp1_q;
    logic [SW-1:0]     big1_q, small1_q;

    logic              v2_q, spec2_q, spec_inv2_q, sign2_q, zsign2_q;
    logic [I_DATA-1:0] spec_res2_q;
    logic [I_EXP-1:0]  exp2_q;
    logic [SW:0]       sum2_q;
    logic [SW:0]       sum_d;

    logic              out_valid_q;
    logic [I_DATA-1:0] result_q;
    logic [3:0]        flags_q;

    // ---------------- S3 combinational ----------------
    logic [SHW-1:0]       lz;
    logic [SW-1:0]        norm;
    logic signed [EW-1:0] exp_e, exp_n, exp_r;
    logic [I_MNT-1:0]     mant_f;
    logic                 inexact;
    logic [I_DATA-1:0]    res_d;
    logic [3:0]           flg_d;
`ifdef FADD_SUB_PIPE_RNE_EN
    logic [I_MNT:0]       mant_inc;
`endif

    function automatic logic [SHW-1:0] lzc(input logic [SW-1:0] v);
        logic [SHW-1:0] cnt;
        logic           found;
        cnt   = SHW'(SW);
        found = 1'b0;
        for (int unsigned i = 0; i < SW; i++) begin
            if (!found && v[SW-1-i]) begin
                cnt   = SHW'(i);
                found = 1'b1;
            end
        end
        return cnt;
    endfunction

    assign adv       = ~out_valid_q | out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

    always_comb begin : s1_unpack
        a_sign = a_operand[I_DATA-1];
        b_sign = b_operand[I_DATA-1] ^ sub;
        a_exp  = a_operand[I_DATA-2:I_MNT];
        b_exp  = b_operand[I_DATA-2:I_MNT];
        a_man  = a_operand[I_MNT-1:0];
        b_man  = b_operand[I_MNT-1:0];
        a_nan  = (a_exp == '1) && (a_man != '0);
        b_nan  = (b_exp == '1) && (b_man != '0);
        a_inf  = (a_exp == '1) && (a_man == '0);
        b_inf  = (b_exp == '1) && (b_man == '0);
        // Exponent-0 operands collapse to a zero magnitude
        a_mag  = (a_exp == '0) ? '0 : {a_exp, a_man};
        b_mag  = (b_exp == '0) ? '0 : {b_exp, b_man};

        a_ge      = (a_mag >= b_mag);
        big_mag   = a_ge ? a_mag : b_mag;
        small_mag = a_ge ? b_mag : a_mag;
        big_sign  = a_ge ? a_sign : b_sign;
        big_exp   = big_mag[I_DATA-2:I_MNT];
        small_exp = small_mag[I_DATA-2:I_MNT];
        big_sig   = {(big_exp != '0), big_mag[I_MNT-1:0], 3'b000};
        small_sig = {(small_exp != '0), small_mag[I_MNT-1:0], 3'b000};

        diff = big_exp - small_exp;
        if (32'(diff) > SHIFT_MAX) begin
            shamt = SHW'(SHIFT_MAX);
        end else begin
            shamt = SHW'(diff);
        end
        // Shifted-out bits fold into the sticky position
        mask     = ~({SW{1'b1}} << shamt);
        small_al = (small_sig >> shamt) | {{(SW-1){1'b0}}, |(small_sig & mask)};

        spec_d     = a_nan | b_nan | a_inf | b_inf;
        spec_inv_d = 1'b0;
        spec_res_d = QNAN;
        if (a_nan || b_nan) begin
            spec_res_d = QNAN;
        end else if (a_inf && b_inf && (a_sign != b_sign)) begin
            spec_res_d = QNAN;
            spec_inv_d = 1'b1;
        end else if (a_inf) begin
            spec_res_d = {a_sign, {I_EXP{1'b1}}, {I_MNT{1'b0}}};
        end else if (b_inf) begin
            spec_res_d = {b_sign, {I_EXP{1'b1}}, {I_MNT{1'b0}}};
        end
    end

    // Larger magnitude is always the base, so the difference is never negative
    always_comb begin : s2_add
        sum_d = eff_sub1_q ? ({1'b0, big1_q} - {1'b0, small1_q})
                           : ({1'b0, big1_q} + {1'b0, small1_q});
    end

    always_comb begin : s3_norm_round
        exp_e = signed'({2'b00, exp2_q});
        lz    = lzc(sum2_q[SW-1:0]);
        if (sum2_q[SW]) begin
            norm  = sum2_q[SW:1] | {{(SW-1){1'b0}}, sum2_q[0]};
            exp_n = exp_e + EW'(1);
        end else begin
            // All-zero sum shifts out completely, leaving the hidden bit clear
            norm  = sum2_q[SW-1:0] << lz;
            exp_n = exp_e - EW'(lz);
        end
        inexact = |norm[2:0];

`ifdef FADD_SUB_PIPE_RNE_EN
        mant_inc = {1'b0, norm[SW-2:3]}
                 + {{I_MNT{1'b0}}, norm[2] & (norm[1] | norm[0] | norm[3])};
        mant_f   = mant_inc[I_MNT-1:0];
        exp_r    = exp_n + EW'(mant_inc[I_MNT]);
`else
        mant_f   = norm[SW-2:3];
        exp_r    = exp_n;
`endif

        res_d = '0;
        flg_d = '0;
        if (spec2_q) begin
            res_d = spec_res2_q;
            flg_d = {spec_inv2_q, 3'b000};
        end else if (!norm[SW-1]) begin
            res_d = {zsign2_q, {(I_DATA-1){1'b0}}};
            flg_d = 4'b0001;
        end else if (exp_n[EW-1] || (exp_n == '0)) begin
            res_d = {sign2_q, {(I_DATA-1){1'b0}}};
            flg_d = 4'b0011;
        end else if (exp_r >= EXP_MAX_S) begin
`ifdef FADD_SUB_PIPE_RNE_EN
            res_d = {sign2_q, {I_EXP{1'b1}}, {I_MNT{1'b0}}};
`else
            res_d = {sign2_q, {(I_EXP-1){1'b1}}, 1'b0, {I_MNT{1'b1}}};
`endif
            flg_d = 4'b0110;
        end else begin
            res_d = {sign2_q, exp_r[I_EXP-1:0], mant_f};
            flg_d = {2'b00, inexact, 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            spec1_q     <= 1'b0;
            spec_inv1_q <= 1'b0;
            spec_res1_q <= '0;
            sign1_q     <= 1'b0;
            eff_sub1_q  <= 1'b0;
            zsign1_q    <= 1'b0;
            exp1_q      <= '0;
            big1_q      <= '0;
            small1_q    <= '0;
            v2_q        <= 1'b0;
            spec2_q     <= 1'b0;
            spec_inv2_q <= 1'b0;
            spec_res2_q <= '0;
            sign2_q     <= 1'b0;
            zsign2_q    <= 1'b0;
            exp2_q      <= '0;
            sum2_q      <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else if (adv) begin
            v1_q        <= in_valid;
            spec1_q     <= spec_d;
            spec_inv1_q <= spec_inv_d;
            spec_res1_q <= spec_res_d;
            sign1_q     <= big_sign;
            eff_sub1_q  <= a_sign ^ b_sign;
            // Exact zero is -0 only when both effective operands are negative
            zsign1_q    <= a_sign & b_sign;
            exp1_q      <= big_exp;
            big1_q      <= big_sig;
            small1_q    <= small_al;
            v2_q        <= v1_q;
            spec2_q     <= spec1_q;
            spec_inv2_q <= spec_inv1_q;
            spec_res2_q <= spec_res1_q;
            sign2_q     <= sign1_q;
            zsign2_q    <= zsign1_q;
            exp2_q      <= exp1_q;
            sum2_q      <= sum_d;
            out_valid_q <= v2_q;
            result_q    <= res_d;
            flags_q     <= flg_d;
        end
    end

endmodule

// File: tb/tb_fadd_sub_pipe.sv
module tb_fadd_sub_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a_operand = '0;
    logic [31:0] b_operand = '0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic [3:0]  flags;

    fadd_sub_pipe #(.I_EXP(8), .I_MNT(23), .I_DATA(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_operand (a_operand),
        .b_operand (b_operand),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

`ifdef FADD_SUB_PIPE_RNE_EN
    localparam logic [31:0] R_SMALL   = 32'h3F800001;
    localparam logic [31:0] R_OVF     = 32'h7F800000;
    localparam logic [31:0] R_TIE_ODD = 32'h3F800002;
`else
    localparam logic [31:0] R_SMALL   = 32'h3F800000;
    localparam logic [31:0] R_OVF     = 32'h7F7FFFFF;
    localparam logic [31:0] R_TIE_ODD = 32'h3F800001;
`endif

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [35:0] exp_q[$];
    int          id_q[$];
    int          next_id = 0;

    logic        stall_pend = 1'b0;
    logic [31:0] held_res;
    logic [3:0]  held_flg;
    logic [35:0] mon_e;
    int          mon_id;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got %h expected %h", name, got, want);
        end
    endtask

    // Presents one operand pair; the expectation is queued on the cycle it is accepted.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] er, input logic [3:0] ef);
        logic done;
        done      = 1'b0;
        in_valid  = 1'b1;
        a_operand = a;
        b_operand = b;
        sub       = s;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({er, ef});
                id_q.push_back(next_id);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        next_id++;
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout got in_ready=0 expected 1");
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && exp_q.size() > 0; t++) @(posedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout got %0d pending expected 0", exp_q.size());
        end
    endtask

    // Output monitor: pops the scoreboard on each accepted result and checks
    // that a stalled result stays put.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_pend) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_result", result, held_res);
                check("hold_flags", 32'(flags), 32'(held_flg));
                stall_pend = 1'b0;
            end
            if (out_valid) begin
                if (!out_ready) begin
                    check("stall_in_ready", 32'(in_ready), 32'd0);
                    held_res   = result;
                    held_flg   = flags;
                    stall_pend = 1'b1;
                end else if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output got %h expected none", result);
                end else begin
                    mon_e  = exp_q.pop_front();
                    mon_id = id_q.pop_front();
                    check($sformatf("vec%0d_result", mon_id), result, mon_e[35:4]);
                    check($sformatf("vec%0d_flags", mon_id), 32'(flags), 32'(mon_e[3:0]));
                end
            end
        end else begin
            stall_pend = 1'b0;
        end
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] r;
        logic [3:0]  f;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vecs.push_back('{32'h3F800000, 32'h33C00000, 1'b0, R_SMALL,      4'b0010});
        vecs.push_back('{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0001});
        vecs.push_back('{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000});
        vecs.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, R_OVF,        4'b0110});
        vecs.push_back('{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000});
        vecs.push_back('{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000});
        vecs.push_back('{32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000, 4'b0000});
        vecs.push_back('{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0001});
        vecs.push_back('{32'h00000001, 32'h00000000, 1'b0, 32'h00000000, 4'b0001});
        vecs.push_back('{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011});
        vecs.push_back('{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000});
        vecs.push_back('{32'h3F800000, 32'h40400000, 1'b1, 32'hC0000000, 4'b0000});
        vecs.push_back('{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0010});
        vecs.push_back('{32'h3F800001, 32'h33800000, 1'b0, R_TIE_ODD,    4'b0010});
        vecs.push_back('{32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 4'b0000});
        vecs.push_back('{32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 4'b0010});
        vecs.push_back('{32'h3F800000, 32'hBF800000, 1'b1, 32'h40000000, 4'b0000});

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'h0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency of the first transaction
        send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
        check("lat_c1", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("lat_c2", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("lat_c3", 32'(out_valid), 32'd1);
        drain();

        // Directed vectors, back to back
        foreach (vecs[i]) send(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].r, vecs[i].f);
        drain();

        // Five back-to-back ops with downstream stalled for three cycles
        fork
            begin
                send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000);
                send(32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 4'b0000);
                send(32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 4'b0000);
                send(32'h40800000, 32'h3F800000, 1'b0, 32'h40A00000, 4'b0000);
                send(32'h40A00000, 32'h3F800000, 1'b0, 32'h40C00000, 4'b0000);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two ops in flight
        send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
        send(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'b0000);
        rst_n = 1'b0;
        exp_q.delete();
        id_q.delete();
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_result", result, 32'h0);
        check("midrst_flags", 32'(flags), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("postrst_idle", 32'(out_valid), 32'd0);
        send(32'h40400000, 32'h40400000, 1'b0, 32'h40C00000, 4'b0000);
        drain();

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fadd_sub_pipe.md
FADD_SUB_PIPE -- requirements
Module: fadd_sub_pipe

Interface
REQ-001 SHALL have parameter I_EXP, default 8, exponent width.
REQ-002 SHALL have parameter I_MNT, default 23, stored mantissa width.
REQ-003 SHALL have parameter I_DATA, default I_EXP+I_MNT+1, operand/result width.
REQ-004 SHALL have port clk  input  1  single clock; all state rising-edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  operand pair valid.
REQ-007 SHALL have port in_ready  output  1  block accepts operand pair this cycle.
REQ-008 SHALL have port a_operand  input  I_DATA  IEEE-style operand A.
REQ-009 SHALL have port b_operand  input  I_DATA  IEEE-style operand B.
REQ-010 SHALL have port sub  input  1  1 = compute A-B, 0 = A+B.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port result  output  I_DATA  sum/difference.
REQ-014 SHALL have port flags  output  4  {invalid, overflow, inexact, zero}, qualified by out_valid.

Function
REQ-015 SHALL implement a 3-stage pipeline: S1 unpack/compare/align, S2 significand add/sub, S3 normalise/round/pack.
REQ-016 SHALL advance all stages together when adv = ~out_valid | out_ready; in_ready SHALL equal adv (combinational).
REQ-017 SHALL transfer input on in_valid & in_ready; each transfer produces exactly one result, in order, 3 cycles later when adv stays high.
REQ-018 SHALL hold result, flags and out_valid stable while out_valid & ~out_ready; bubbles propagate as invalid stages.
REQ-019 SHALL effective-sign B as b_operand[I_DATA-1] ^ sub.
REQ-020 SHALL treat exponent-0 inputs as zero (flush subnormals); SHALL never emit subnormals (underflow -> signed zero, inexact=1).
REQ-021 SHALL swap so the larger-magnitude operand is the base; align the smaller by min(exp_diff, I_MNT+3) with guard, round, sticky bits (sticky = OR of all shifted-out bits).
REQ-022 SHALL normalise with a leading-zero count over I_MNT+4 bits (one right shift on carry-out), not a loop bounded by exponent.
REQ-023 SHALL flag overflow and return signed infinity when the rounded exponent reaches 2^I_EXP-1.
REQ-024 Exact-zero result SHALL be +0, except (-0)+(-0) -> -0; zero flag set for any zero result.
REQ-025 Any NaN input, or Inf + (-Inf) effective, SHALL return canonical NaN {0, all-ones exp, 1, zeros} with invalid=1 for the Inf case only.
REQ-026 Inf with finite SHALL return that Inf; Inf+Inf same sign returns that Inf; no flags.
REQ-027 inexact SHALL be set when guard|round|sticky is nonzero after normalisation or on overflow.

Reset
REQ-028 While rst_n low: all stage valids, out_valid, result, flags SHALL be 0; in_ready SHALL be 1.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight operations; first output after release comes from a post-reset input.

Configuration
REQ-030 Macro FADD_SUB_PIPE_RNE_EN defined: S3 SHALL round-to-nearest-even (increment when G & (R|S|LSB)), renormalising on mantissa carry.
REQ-031 Macro FADD_SUB_PIPE_RNE_EN undefined: S3 SHALL truncate (round toward zero); inexact still reported; overflow then saturates to max finite instead of Inf.

Verification
REQ-032 0x3F800000 + 0x40000000, sub=0, out_ready=1 -> 0x40400000 at cycle 3, flags=0000.
REQ-033 0x3F800000 + 0x33C00000 -> 0x3F800001 inexact with RNE_EN; 0x3F800000 inexact without.
REQ-034 0x3F800000 - 0x3F800000 (sub=1) -> 0x00000000, zero=1; 0x7F800000 - 0x7F800000 -> 0x7FC00000, invalid=1.
REQ-035 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000 overflow+inexact (RNE_EN), 0x7F7FFFFF without.
REQ-036 Back-to-back 5 inputs with out_ready low cycles 4-6 -> in_ready low those cycles, results held stable, all 5 emitted in order, none lost or duplicated.
REQ-037 rst_n pulsed low with 2 ops in flight -> out_valid 0 immediately, no stale result after release.
